// File: rtl/my_control_unit.sv
// Hardwired control unit for the basic computer: a 3-bit sequence counter steps
// fetch, decode, indirect and execute phases and drives every datapath control line.
module my_control_unit #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 16,
  parameter int START_RUN = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] out_IR,
  input  logic [DATA_W-1:0] out_DR,
  input  logic [DATA_W-1:0] out_AC,
  input  logic              e_alu,
  output logic [2:0]        alu_op,
  output logic [2:0]        select_bus,
  output logic              rst_AR,
  output logic              rst_DR,
  output logic              rst_PC,
  output logic              rst_TR,
  output logic              rst_IR,
  output logic              rst_AC,
  output logic              rst_e,
  output logic              enable_AR,
  output logic              enable_DR,
  output logic              enable_PC,
  output logic              enable_TR,
  output logic              enable_IR,
  output logic              enable_AC,
  output logic              enable_mem,
  output logic              enable_e,
  output logic              incr_AR,
  output logic              incr_DR,
  output logic              incr_PC,
  output logic              incr_TR,
  output logic              incr_IR,
  output logic              incr_AC,
  output logic              incr_e,
  output logic              halted,
  output logic [2:0]        sc
);

  localparam logic [2:0] T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3,
                         T4 = 3'd4, T5 = 3'd5, T6 = 3'd6;
  localparam logic [2:0] OP_AND = 3'd0, OP_ADD = 3'd1, OP_LDA = 3'd2, OP_STA = 3'd3,
                         OP_BUN = 3'd4, OP_BSA = 3'd5, OP_ISZ = 3'd6, OP_REG = 3'd7;
  localparam logic [2:0] SEL_AR = 3'd1, SEL_PC = 3'd2, SEL_DR = 3'd3, SEL_AC = 3'd4,
                         SEL_IR = 3'd5, SEL_MEM = 3'd7;
  localparam logic [2:0] ALU_AND = 3'd0, ALU_ADD = 3'd1, ALU_XFER = 3'd2, ALU_COM = 3'd3,
                         ALU_SHR = 3'd4, ALU_SHL = 3'd5, ALU_CME = 3'd6;

  logic [2:0]        sc_q, sc_d;
  logic              i_q, i_d;
  logic              s_q, s_d;
  logic [2:0]        d;
  logic [ADDR_W-1:0] rr;

  assign d  = out_IR[DATA_W-2 -: 3];
  assign rr = out_IR[ADDR_W-1:0];

  always_comb begin
    alu_op     = 3'd0;
    select_bus = 3'd0;
    {rst_AR, rst_DR, rst_PC, rst_TR, rst_IR, rst_AC, rst_e} = '0;
    {enable_AR, enable_DR, enable_PC, enable_TR, enable_IR, enable_AC, enable_mem, enable_e} = '0;
    {incr_AR, incr_DR, incr_PC, incr_TR, incr_IR, incr_AC, incr_e} = '0;
    sc_d = sc_q;
    i_d  = i_q;
    s_d  = s_q;
    if (!rst_n) begin
      {rst_AR, rst_DR, rst_PC, rst_TR, rst_IR, rst_AC, rst_e} = '1;
    end else if (!s_q) begin
      sc_d = T0;
      if (start) s_d = 1'b1;
    end else begin
      sc_d = sc_q + 3'd1;
      case (sc_q)
        T0: begin select_bus = SEL_PC;  enable_AR = 1'b1; end
        T1: begin select_bus = SEL_MEM; enable_IR = 1'b1; incr_PC = 1'b1; end
        T2: begin select_bus = SEL_IR;  enable_AR = 1'b1; i_d = out_IR[DATA_W-1]; end
        T3: begin
          if (d == OP_REG) begin
            sc_d = T0;
            // Register-reference: only the most significant set bit acts.
            if (!i_q) begin
              if      (rr[11]) rst_AC = 1'b1;
              else if (rr[10]) rst_e  = 1'b1;
              else if (rr[9])  begin alu_op = ALU_COM; enable_AC = 1'b1; end
              else if (rr[8])  begin alu_op = ALU_CME; enable_e  = 1'b1; end
              else if (rr[7])  begin alu_op = ALU_SHR; enable_AC = 1'b1; enable_e = 1'b1; end
              else if (rr[6])  begin alu_op = ALU_SHL; enable_AC = 1'b1; enable_e = 1'b1; end
              else if (rr[5])  incr_AC = 1'b1;
              else if (rr[4])  incr_PC = ~out_AC[DATA_W-1];
              else if (rr[3])  incr_PC = out_AC[DATA_W-1];
              else if (rr[2])  incr_PC = (out_AC == '0);
              else if (rr[1])  incr_PC = ~e_alu;
              else if (rr[0])  s_d = 1'b0;
            end
          end else if (i_q) begin
            select_bus = SEL_MEM;
            enable_AR  = 1'b1;
          end
        end
        T4: begin
          case (d)
            OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin select_bus = SEL_MEM; enable_DR = 1'b1; end
            OP_STA: begin select_bus = SEL_AC; enable_mem = 1'b1; sc_d = T0; end
            OP_BUN: begin select_bus = SEL_AR; enable_PC = 1'b1; sc_d = T0; end
            OP_BSA: begin select_bus = SEL_PC; enable_mem = 1'b1; incr_AR = 1'b1; end
            default: sc_d = T0;
          endcase
        end
        T5: begin
          sc_d = T0;
          case (d)
            OP_AND: begin alu_op = ALU_AND;  enable_AC = 1'b1; end
            OP_ADD: begin alu_op = ALU_ADD;  enable_AC = 1'b1; enable_e = 1'b1; end
            OP_LDA: begin alu_op = ALU_XFER; enable_AC = 1'b1; end
            OP_BSA: begin select_bus = SEL_AR; enable_PC = 1'b1; end
            OP_ISZ: begin incr_DR = 1'b1; sc_d = T6; end
            default: ;
          endcase
        end
        T6: begin
          sc_d = T0;
          if (d == OP_ISZ) begin
            select_bus = SEL_DR;
            enable_mem = 1'b1;
            incr_PC    = (out_DR == '0);
          end
        end
        default: sc_d = T0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sc_q <= T0;
      i_q  <= 1'b0;
      s_q  <= (START_RUN != 0);
    end else begin
      sc_q <= sc_d;
      i_q  <= i_d;
      s_q  <= s_d;
    end
  end

  assign halted = ~s_q;
  assign sc     = sc_q;

endmodule
